dev_bridge: RTL and testbench

//  CPU-side initiator for the peripheral device bus: takes one word load/store request per

---
 rtl/dev_bridge.sv | 192 +++++++++++++++++++
 tb/tb_dev_bridge.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dev_bridge.sv
// dev_bridge: CPU-side initiator for the peripheral device bus.
// Decodes one word load/store per transaction to DEV0 or DEV1.
//
// Ports:
//   clk, reset          : clock (rising edge), async active-high reset
//   cpu_req/we/addr/wd  : CPU request; req is held until cpu_ack
//   cpu_rd/ack/err      : registered load data, 1-cycle ack, miss flag
//   DEV_Addr/DEV_WD     : shared device address / write data
//   DEV0_WE/DEV1_WE     : per-device write strobes (one ACCESS cycle)
//   DEV0_RD/DEV1_RD     : device read data, combinational on DEV_Addr
//   intrp0/intrp1       : device interrupt levels
//   HWInt               : registered {4'b0, intrp1, intrp0} & mask
//
// Build option: define BRIDGE_INT_MASK_EN to add a writable 6-bit
// interrupt mask register at DEV1_BASE+DEV_SPAN+4.

module dev_bridge #(
  parameter logic [31:0] DEV0_BASE = 32'h0000_7f00,
  parameter logic [31:0] DEV1_BASE = 32'h0000_7f10,
  parameter int unsigned DEV_SPAN  = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wd,
  output logic [31:0] cpu_rd,
  output logic        cpu_ack,
  output logic        cpu_err,
  output logic [31:0] DEV_Addr,
  output logic [31:0] DEV_WD,
  output logic        DEV0_WE,
  output logic        DEV1_WE,
  input  logic [31:0] DEV0_RD,
  input  logic [31:0] DEV1_RD,
  input  logic        intrp0,
  input  logic        intrp1,
  output logic [5:0]  HWInt
);

  localparam logic [31:0] L_SPAN = 32'(DEV_SPAN);
  localparam logic [31:0] L_END0 = DEV0_BASE + L_SPAN;
  localparam logic [31:0] L_END1 = DEV1_BASE + L_SPAN;
  localparam logic [31:0] L_MADR = L_END1 + 32'd4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [31:0] r_addr;
  logic [31:0] r_wd;
  logic        r_we;
  logic        r_hit0;
  logic        r_hit1;
  logic        r_hitm;
  logic [31:0] r_rd;
  logic [5:0]  r_hwint;

  logic        w_algn;
  logic        w_in0;
  logic        w_in1;
  logic        w_hit1;
  logic        w_hitm;
  logic        w_accept;
  logic [31:0] w_rd_sel;
  logic [5:0]  w_mask;

  // Address decode; DEV0 wins if the windows overlap.
  always_comb begin
    w_algn = (cpu_addr[1:0] == 2'b00);
    w_in0  = w_algn && (cpu_addr >= DEV0_BASE) && (cpu_addr < L_END0);
    w_in1  = w_algn && (cpu_addr >= DEV1_BASE) && (cpu_addr < L_END1);
    w_hit1 = w_in1 && !w_in0;
`ifdef BRIDGE_INT_MASK_EN
    w_hitm = w_algn && (cpu_addr == L_MADR) && !w_in0 && !w_in1;
`else
    w_hitm = 1'b0;
`endif
  end

  assign w_accept = (r_state == S_IDLE) && cpu_req;

  // Read-data select at the end of ACCESS; stores and misses return 0.
  always_comb begin
    w_rd_sel = 32'd0;
    if (!r_we) begin
      if (r_hit0)
        w_rd_sel = DEV0_RD;
      else if (r_hit1)
        w_rd_sel = DEV1_RD;
      else if (r_hitm)
        w_rd_sel = {26'd0, w_mask};
    end
  end

`ifdef BRIDGE_INT_MASK_EN
  logic [5:0] r_mask;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_mask <= 6'h3f;
    else if (r_state == S_ACCESS && r_we && r_hitm)
      r_mask <= r_wd[5:0];
  end

  assign w_mask = r_mask;
`else
  assign w_mask = 6'h3f;
`endif

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  // FSM next state
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (cpu_req) w_next = S_ACCESS;
      S_ACCESS: w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // FSM outputs; strobes are combinational so reset drops them at once.
  always_comb begin
    DEV0_WE = 1'b0;
    DEV1_WE = 1'b0;
    cpu_ack = 1'b0;
    cpu_err = 1'b0;
    unique case (r_state)
      S_ACCESS: begin
        DEV0_WE = r_we && r_hit0;
        DEV1_WE = r_we && r_hit1;
      end
      S_RESP: begin
        cpu_ack = 1'b1;
        cpu_err = !(r_hit0 || r_hit1 || r_hitm);
      end
      default: ;
    endcase
  end

  // Request latch and read-data capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr <= 32'd0;
      r_wd   <= 32'd0;
      r_we   <= 1'b0;
      r_hit0 <= 1'b0;
      r_hit1 <= 1'b0;
      r_hitm <= 1'b0;
      r_rd   <= 32'd0;
    end else begin
      if (w_accept) begin
        r_addr <= cpu_addr;
        r_wd   <= cpu_wd;
        r_we   <= cpu_we;
        r_hit0 <= w_in0;
        r_hit1 <= w_hit1;
        r_hitm <= w_hitm;
      end
      if (r_state == S_ACCESS)
        r_rd <= w_rd_sel;
    end
  end

  // Interrupt levels are re-sampled every edge, never latched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_hwint <= 6'd0;
    else
      r_hwint <= {4'd0, intrp1, intrp0} & w_mask;
  end

  assign cpu_rd   = r_rd;
  assign DEV_Addr = r_addr;
  assign DEV_WD   = r_wd;
  assign HWInt    = r_hwint;

endmodule

// File: tb/tb_dev_bridge.sv
// tb_dev_bridge: directed self-checking bench for dev_bridge.
// Outputs are sampled 1 time unit after each rising edge.

module tb_dev_bridge;

  logic        clk;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wd;
  logic [31:0] cpu_rd;
  logic        cpu_ack;
  logic        cpu_err;
  logic [31:0] DEV_Addr;
  logic [31:0] DEV_WD;
  logic        DEV0_WE;
  logic        DEV1_WE;
  logic [31:0] DEV0_RD;
  logic [31:0] DEV1_RD;
  logic        intrp0;
  logic        intrp1;
  logic [5:0]  HWInt;

  int n_vec;
  int n_err;

  dev_bridge dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wd   (cpu_wd),
    .cpu_rd   (cpu_rd),
    .cpu_ack  (cpu_ack),
    .cpu_err  (cpu_err),
    .DEV_Addr (DEV_Addr),
    .DEV_WD   (DEV_WD),
    .DEV0_WE  (DEV0_WE),
    .DEV1_WE  (DEV1_WE),
    .DEV0_RD  (DEV0_RD),
    .DEV1_RD  (DEV1_RD),
    .intrp0   (intrp0),
    .intrp1   (intrp1),
    .HWInt    (HWInt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic we, input logic [31:0] a,
                     input logic [31:0] d);
    cpu_req  = 1'b1;
    cpu_we   = we;
    cpu_addr = a;
    cpu_wd   = d;
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    reset    = 1'b1;
    cpu_req  = 1'b0;
    cpu_we   = 1'b0;
    cpu_addr = 32'd0;
    cpu_wd   = 32'd0;
    DEV0_RD  = 32'hA5A5_0001;
    DEV1_RD  = 32'h0000_0055;
    intrp0   = 1'b0;
    intrp1   = 1'b0;

    // Reset state
    step();
    chk("rst_ack", {31'd0, cpu_ack}, 32'd0);
    chk("rst_rd", cpu_rd, 32'd0);
    chk("rst_addr", DEV_Addr, 32'd0);
    chk("rst_wd", DEV_WD, 32'd0);
    chk("rst_we", {30'd0, DEV1_WE, DEV0_WE}, 32'd0);
    chk("rst_hwint", {26'd0, HWInt}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step();

    // Store 7 to DEV0 word 1
    req(1'b1, 32'h7f04, 32'd7);
    step();
    chk("st0_we0", {31'd0, DEV0_WE}, 32'd1);
    chk("st0_we1", {31'd0, DEV1_WE}, 32'd0);
    chk("st0_addr", DEV_Addr, 32'h7f04);
    chk("st0_wd", DEV_WD, 32'd7);
    chk("st0_noack", {31'd0, cpu_ack}, 32'd0);
    cpu_req = 1'b0;
    step();
    chk("st0_ack", {31'd0, cpu_ack}, 32'd1);
    chk("st0_err", {31'd0, cpu_err}, 32'd0);
    chk("st0_we_off", {31'd0, DEV0_WE}, 32'd0);
    step();
    chk("st0_idle", {31'd0, cpu_ack}, 32'd0);
    chk("st0_hold", DEV_Addr, 32'h7f04);

    // Load DEV1 last word
    req(1'b0, 32'h7f18, 32'd0);
    step();
    chk("ld1_we", {30'd0, DEV1_WE, DEV0_WE}, 32'd0);
    chk("ld1_addr", DEV_Addr, 32'h7f18);
    cpu_req = 1'b0;
    step();
    chk("ld1_ack", {31'd0, cpu_ack}, 32'd1);
    chk("ld1_rd", cpu_rd, 32'h55);
    chk("ld1_err", {31'd0, cpu_err}, 32'd0);
    step();

    // Load DEV0 base word
    req(1'b0, 32'h7f00, 32'd0);
    step();
    cpu_req = 1'b0;
    step();
    chk("ld0_rd", cpu_rd, 32'hA5A5_0001);
    chk("ld0_err", {31'd0, cpu_err}, 32'd0);
    step();

    // Miss: unmapped load
    req(1'b0, 32'h7f30, 32'd0);
    step();
    chk("mis_we", {30'd0, DEV1_WE, DEV0_WE}, 32'd0);
    cpu_req = 1'b0;
    step();
    chk("mis_ack", {31'd0, cpu_ack}, 32'd1);
    chk("mis_err", {31'd0, cpu_err}, 32'd1);
    chk("mis_rd", cpu_rd, 32'd0);
    step();

    // Miss: misaligned store inside DEV0
    req(1'b1, 32'h7f05, 32'd3);
    step();
    chk("mal_we", {30'd0, DEV1_WE, DEV0_WE}, 32'd0);
    cpu_req = 1'b0;
    step();
    chk("mal_err", {31'd0, cpu_err}, 32'd1);
    chk("mal_rd", cpu_rd, 32'd0);
    step();

    // Boundary: first word past DEV0 window
    req(1'b0, 32'h7f0c, 32'd0);
    step();
    cpu_req = 1'b0;
    step();
    chk("end0_err", {31'd0, cpu_err}, 32'd1);
    chk("end0_rd", cpu_rd, 32'd0);
    step();

    // Boundary: store to first word past DEV1 window
    req(1'b1, 32'h7f1c, 32'd9);
    step();
    chk("end1_we", {30'd0, DEV1_WE, DEV0_WE}, 32'd0);
    cpu_req = 1'b0;
    step();
    chk("end1_err", {31'd0, cpu_err}, 32'd1);
    step();

    // Store to DEV1 base, back-to-back with a second store
    req(1'b1, 32'h7f10, 32'h1234);
    step();
    chk("b2b_we1", {30'd0, DEV1_WE, DEV0_WE}, 32'd2);
    step();
    chk("b2b_ack1", {31'd0, cpu_ack}, 32'd1);
    req(1'b1, 32'h7f08, 32'h77);
    step();
    chk("b2b_idle", {30'd0, DEV1_WE, DEV0_WE}, 32'd0);
    chk("b2b_idle_ack", {31'd0, cpu_ack}, 32'd0);
    step();
    chk("b2b_we0", {30'd0, DEV1_WE, DEV0_WE}, 32'd1);
    chk("b2b_addr", DEV_Addr, 32'h7f08);
    chk("b2b_wd", DEV_WD, 32'h77);
    cpu_req = 1'b0;
    step();
    chk("b2b_ack2", {31'd0, cpu_ack}, 32'd1);
    step();

    // Interrupt pass-through, 1-edge latency
    intrp0 = 1'b1;
    #1;
    chk("int_pre", {26'd0, HWInt}, 32'd0);
    step();
    chk("int_0", {26'd0, HWInt}, 32'd1);
    intrp1 = 1'b1;
    step();
    chk("int_01", {26'd0, HWInt}, 32'd3);
    intrp0 = 1'b0;
    step();
    chk("int_1", {26'd0, HWInt}, 32'd2);
    intrp1 = 1'b0;
    step();
    chk("int_off", {26'd0, HWInt}, 32'd0);

    // Reset during ACCESS
    req(1'b1, 32'h7f00, 32'd5);
    step();
    chk("rac_we", {31'd0, DEV0_WE}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rac_we_off", {31'd0, DEV0_WE}, 32'd0);
    chk("rac_addr", DEV_Addr, 32'd0);
    chk("rac_wd", DEV_WD, 32'd0);
    chk("rac_rd", cpu_rd, 32'd0);
    step();
    chk("rac_noack", {31'd0, cpu_ack}, 32'd0);
    req(1'b1, 32'h7f00, 32'd9);
    @(negedge clk);
    reset = 1'b0;
    step();
    chk("rec_we", {31'd0, DEV0_WE}, 32'd1);
    chk("rec_wd", DEV_WD, 32'd9);
    cpu_req = 1'b0;
    step();
    chk("rec_ack", {31'd0, cpu_ack}, 32'd1);
    chk("rec_err", {31'd0, cpu_err}, 32'd0);
    step();

`ifdef BRIDGE_INT_MASK_EN
    // Mask register: clear mask, interrupt suppressed, read back
    req(1'b1, 32'h7f20, 32'd0);
    step();
    chk("msk_we", {30'd0, DEV1_WE, DEV0_WE}, 32'd0);
    cpu_req = 1'b0;
    step();
    chk("msk_err", {31'd0, cpu_err}, 32'd0);
    step();
    intrp0 = 1'b1;
    step();
    step();
    chk("msk_hwint", {26'd0, HWInt}, 32'd0);
    req(1'b0, 32'h7f20, 32'd0);
    step();
    cpu_req = 1'b0;
    step();
    chk("msk_rd", cpu_rd, 32'd0);
    chk("msk_rerr", {31'd0, cpu_err}, 32'd0);
    step();
    req(1'b1, 32'h7f20, 32'h3f);
    step();
    cpu_req = 1'b0;
    step();
    step();
    step();
    chk("msk_on", {26'd0, HWInt}, 32'd1);
    intrp0 = 1'b0;
`else
    // Without the mask option the mask address is unmapped
    intrp0 = 1'b1;
    req(1'b1, 32'h7f20, 32'd0);
    step();
    chk("nmsk_we", {30'd0, DEV1_WE, DEV0_WE}, 32'd0);
    cpu_req = 1'b0;
    step();
    chk("nmsk_err", {31'd0, cpu_err}, 32'd1);
    step();
    chk("nmsk_hwint", {26'd0, HWInt}, 32'd1);
    req(1'b0, 32'h7f20, 32'd0);
    step();
    cpu_req = 1'b0;
    step();
    chk("nmsk_rd", cpu_rd, 32'd0);
    chk("nmsk_rerr", {31'd0, cpu_err}, 32'd1);
    intrp0 = 1'b0;
`endif
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
